// File: rtl/nested_sqrt_fsm_pkg.sv
// Shared types for the nested/summed root formula sequencer.
package nested_sqrt_pkg;
  typedef enum logic [1:0] {IDLE, SEND, WAIT, DONE} state_e;
  typedef enum logic {MODE_NEST = 1'b0, MODE_SUM = 1'b1} mode_e;

  // Index register width, never narrower than one bit (N_TERMS = 1 still needs a flop).
  function automatic int idx_w(input int n);
    return (n < 2) ? 1 : $clog2(n);
  endfunction
endpackage

// File: rtl/nested_sqrt_fsm.sv
// Evaluates an N-term nested or summed root formula by time-sharing one external isqrt unit.
module nested_sqrt_fsm
  import nested_sqrt_pkg::*;
#(
  parameter int N_TERMS = 3,
  parameter int W       = 32
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 arg_vld,
  output logic                 arg_rdy,
  input  logic                 mode,
  input  logic [N_TERMS*W-1:0] args,
  output logic                 res_vld,
  output logic [W-1:0]         res,
  output logic                 isqrt_x_vld,
  output logic [W-1:0]         isqrt_x,
  input  logic                 isqrt_y_vld,
  input  logic [W/2-1:0]       isqrt_y
);
  localparam int IW = idx_w(N_TERMS);
  localparam int HW = W / 2;

  state_e               state_q, state_d;
  mode_e                mode_q, mode_d;
  logic [N_TERMS*W-1:0] args_q, args_d;
  logic [IW-1:0]        idx_q, idx_d;
  logic [W-1:0]         acc_q, acc_d;

  logic [W-1:0] xs [N_TERMS];
  logic [W-1:0] x_sel, opnd, y_ext;

  always_comb begin
    for (int k = 0; k < N_TERMS; k++) xs[k] = args_q[k*W +: W];
  end

  assign x_sel = xs[idx_q];
  // NEST feeds the previous root back into the next operand; the add wraps mod 2^W.
  assign opnd  = (mode_q == MODE_SUM) ? x_sel : x_sel + acc_q;
  assign y_ext = {{(W-HW){1'b0}}, isqrt_y};

  always_comb begin
    state_d     = state_q;
    mode_d      = mode_q;
    args_d      = args_q;
    idx_d       = idx_q;
    acc_d       = acc_q;
    arg_rdy     = 1'b0;
    isqrt_x_vld = 1'b0;
    isqrt_x     = '0;
    res_vld     = 1'b0;
    res         = '0;
    unique case (state_q)
      IDLE: begin
        arg_rdy = 1'b1;
        if (arg_vld) begin
          state_d = SEND;
          mode_d  = mode_e'(mode);
          args_d  = args;
          idx_d   = IW'(N_TERMS - 1);
          acc_d   = '0;
        end
      end
      SEND: begin
        isqrt_x_vld = 1'b1;
        isqrt_x     = opnd;
        state_d     = WAIT;
      end
      WAIT: begin
        if (isqrt_y_vld) begin
          acc_d = (mode_q == MODE_SUM) ? acc_q + y_ext : y_ext;
          if (idx_q == '0) begin
            state_d = DONE;
          end else begin
            idx_d   = idx_q - 1'b1;
            state_d = SEND;
          end
        end
      end
      DONE: begin
        res_vld = 1'b1;
        res     = acc_q;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      mode_q  <= MODE_NEST;
      args_q  <= '0;
      idx_q   <= '0;
      acc_q   <= '0;
    end else begin
      state_q <= state_d;
      mode_q  <= mode_d;
      args_q  <= args_d;
      idx_q   <= idx_d;
      acc_q   <= acc_d;
    end
  end
endmodule

// File: tb/tb_nested_sqrt_fsm.sv
// Directed bench: bench-side isqrt responder with fixed latency, a timing/arithmetic model checked every cycle.
module tb_nested_sqrt_fsm;
  localparam int N  = 3;
  localparam int W  = 32;
  localparam int HW = W / 2;
  localparam int L  = 2;
  localparam int LAT = N * (1 + L) + 1;

  logic           clk = 1'b0;
  logic           rst_n = 1'b0;
  logic           arg_vld = 1'b0;
  logic           mode = 1'b0;
  logic [N*W-1:0] args = '0;
  logic           arg_rdy, res_vld, isqrt_x_vld;
  logic [W-1:0]   res, isqrt_x;
  logic           isqrt_y_vld = 1'b0;
  logic [HW-1:0]  isqrt_y = '0;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;
  int inj_cyc = -1;

  logic [W-1:0] res_q[$];
  logic [W-1:0] xq[$];
  int           acc_cyc_q[$];
  int           res_cyc_q[$];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  nested_sqrt_fsm #(.N_TERMS(N), .W(W)) dut (
    .clk(clk), .rst_n(rst_n), .arg_vld(arg_vld), .arg_rdy(arg_rdy), .mode(mode), .args(args),
    .res_vld(res_vld), .res(res), .isqrt_x_vld(isqrt_x_vld), .isqrt_x(isqrt_x),
    .isqrt_y_vld(isqrt_y_vld), .isqrt_y(isqrt_y)
  );

  function automatic logic [HW-1:0] isqrt_f(input logic [W-1:0] x);
    logic [HW-1:0] r, t;
    longint sq;
    r = '0;
    for (int b = HW - 1; b >= 0; b--) begin
      t  = r | (HW'(1) << b);
      sq = longint'(t) * longint'(t);
      if (sq <= longint'(x)) r = t;
    end
    return r;
  endfunction

  task automatic chk(input string nm, input logic [W-1:0] act, input logic [W-1:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  // isqrt stand-in: answers each request exactly L cycles later; shares rst_n.
  typedef struct { int due; logic [HW-1:0] y; } rsp_t;
  rsp_t rq[$];
  initial forever begin
    @(posedge clk); #2;
    isqrt_y_vld = 1'b0;
    isqrt_y     = '0;
    if (!rst_n) rq.delete();
    else begin
      if (rq.size() > 0 && rq[0].due == cyc) begin
        isqrt_y_vld = 1'b1;
        isqrt_y     = rq[0].y;
        void'(rq.pop_front());
      end else if (inj_cyc == cyc) begin
        isqrt_y_vld = 1'b1;
        isqrt_y     = 16'd123;
      end
      if (isqrt_x_vld) rq.push_back('{cyc + L, isqrt_f(isqrt_x)});
    end
  end

  // Model: per accepted bundle, the full request list and result from plain arithmetic,
  // placed on the timeline SEND(j) = accept+1+j*(1+L), result = accept+LAT.
  initial begin
    logic [W-1:0] mreq[N];
    logic [W-1:0] mres, macc, xk;
    logic         e_rdy, e_xv, e_rv;
    logic [W-1:0] e_x, e_r;
    int           a_cyc, d_cyc, off, j;
    d_cyc = -1; a_cyc = 0; mres = '0;
    for (int k = 0; k < N; k++) mreq[k] = '0;
    forever begin
      @(negedge clk);
      e_rdy = 1'b1; e_xv = 1'b0; e_x = '0; e_rv = 1'b0; e_r = '0;
      if (!rst_n) d_cyc = -1;
      else if (cyc <= d_cyc) begin
        e_rdy = 1'b0;
        off = cyc - a_cyc - 1;
        j   = off / (1 + L);
        if (off % (1 + L) == 0 && j < N) begin e_xv = 1'b1; e_x = mreq[N-1-j]; end
        if (cyc == d_cyc) begin e_rv = 1'b1; e_r = mres; end
      end
      chk("arg_rdy", W'(arg_rdy), W'(e_rdy));
      chk("isqrt_x_vld", W'(isqrt_x_vld), W'(e_xv));
      chk("isqrt_x", isqrt_x, e_x);
      chk("res_vld", W'(res_vld), W'(e_rv));
      chk("res", res, e_r);
      if (rst_n && isqrt_x_vld) xq.push_back(isqrt_x);
      if (rst_n && res_vld) begin res_q.push_back(res); res_cyc_q.push_back(cyc); end
      if (rst_n && e_rdy && arg_vld) begin
        macc = '0;
        for (int k = N - 1; k >= 0; k--) begin
          xk = args[k*W +: W];
          if (mode == 1'b0) begin mreq[k] = xk + macc; macc = {{(W-HW){1'b0}}, isqrt_f(mreq[k])}; end
          else begin mreq[k] = xk; macc = macc + {{(W-HW){1'b0}}, isqrt_f(xk)}; end
        end
        mres  = macc;
        a_cyc = cyc;
        d_cyc = cyc + LAT;
        acc_cyc_q.push_back(cyc);
      end
    end
  end

  task automatic put(input logic m, input logic [W-1:0] a0, input logic [W-1:0] a1, input logic [W-1:0] a2);
    mode = m; args = {a2, a1, a0}; arg_vld = 1'b1;
  endtask

  // Returns at posedge+#1 of the first cycle after the accepting edge.
  task automatic wait_acc(input string nm);
    int n;
    n = 0;
    forever begin
      @(negedge clk);
      if (arg_rdy && arg_vld) break;
      n++;
      if (n > 60) begin total++; bad++; $display("FAIL %s: accept timeout", nm); break; end
    end
    @(posedge clk); #1;
  endtask

  task automatic wait_res(input string nm, input int cnt);
    int n;
    n = 0;
    while (res_q.size() < cnt) begin
      @(negedge clk);
      n++;
      if (n > 100) begin total++; bad++; $display("FAIL %s: result timeout", nm); break; end
    end
    @(posedge clk); #1;
  endtask

  task automatic chk_seq(input string nm, input int n0, input logic [W-1:0] e0,
                         input logic [W-1:0] e1, input logic [W-1:0] e2);
    if (xq.size() < n0 + 3) begin
      total++; bad++; $display("FAIL %s: only %0d requests seen", nm, xq.size() - n0);
    end else begin
      chk({nm, " x[0]"}, xq[n0], e0);
      chk({nm, " x[1]"}, xq[n0+1], e1);
      chk({nm, " x[2]"}, xq[n0+2], e2);
    end
  endtask

  initial begin
    int n0, r0;
    repeat (2) @(posedge clk);
    #1;
    chk("reset arg_rdy", W'(arg_rdy), 32'd1);
    chk("reset res_vld", W'(res_vld), 32'd0);
    chk("reset isqrt_x_vld", W'(isqrt_x_vld), 32'd0);
    rst_n = 1'b1;
    @(posedge clk); #1;

    // NEST 2,7,4 with a stray isqrt_y in IDLE and in SEND
    inj_cyc = cyc;
    @(posedge clk); #1;
    n0 = xq.size();
    put(1'b0, 32'd2, 32'd7, 32'd4);
    wait_acc("nest");
    arg_vld = 1'b0;
    inj_cyc = cyc;
    wait_res("nest", 1);
    chk("nest res", res_q[0], 32'd2);
    chk_seq("nest", n0, 32'd4, 32'd9, 32'd5);
    chk("nest latency", W'(res_cyc_q[0] - acc_cyc_q[0]), 32'd10);

    // SUM 16,9,4
    n0 = xq.size();
    put(1'b1, 32'd16, 32'd9, 32'd4);
    wait_acc("sum");
    arg_vld = 1'b0;
    wait_res("sum", 2);
    chk("sum res", res_q[1], 32'd9);
    chk_seq("sum", n0, 32'd4, 32'd9, 32'd16);

    // NEST with operand wrap
    n0 = xq.size();
    put(1'b0, 32'hFFFF0001, 32'hFFFFFFFF, 32'h0);
    wait_acc("wrap");
    arg_vld = 1'b0;
    wait_res("wrap", 3);
    chk("wrap res", res_q[2], 32'd0);
    chk_seq("wrap", n0, 32'h0, 32'hFFFFFFFF, 32'h0);

    // back-to-back with arg_vld held high
    put(1'b0, 32'd2, 32'd7, 32'd4);
    wait_acc("b2b first");
    put(1'b1, 32'd16, 32'd9, 32'd4);
    wait_acc("b2b second");
    arg_vld = 1'b0;
    wait_res("b2b", 5);
    chk("b2b res A", res_q[3], 32'd2);
    chk("b2b res B", res_q[4], 32'd9);
    chk("b2b gap", W'(acc_cyc_q[4] - res_cyc_q[3]), 32'd1);

    // reset during the second WAIT aborts without a result
    put(1'b0, 32'd2, 32'd7, 32'd4);
    wait_acc("abort");
    arg_vld = 1'b0;
    repeat (L + 2) @(posedge clk);
    #3;
    r0 = res_q.size();
    rst_n = 1'b0;
    #1;
    chk("abort arg_rdy", W'(arg_rdy), 32'd1);
    chk("abort isqrt_x_vld", W'(isqrt_x_vld), 32'd0);
    chk("abort res_vld", W'(res_vld), 32'd0);
    chk("abort res", res, 32'd0);
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    repeat (LAT) @(posedge clk);
    #1;
    chk("abort no result", W'(res_q.size()), W'(r0));
    put(1'b0, 32'd2, 32'd7, 32'd4);
    wait_acc("after abort");
    arg_vld = 1'b0;
    wait_res("after abort", r0 + 1);
    if (res_q.size() > r0) chk("after abort res", res_q[r0], 32'd2);

    repeat (3) @(posedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/nested_sqrt_fsm.md
Name: nested_sqrt_fsm

Overview:
- Computes an N-term root formula over one shared external isqrt unit, in one of two modes selected per transaction.
  - NEST mode: res = isqrt(x0 + isqrt(x1 + ... isqrt(x[N-1]))).
  - SUM mode: res = isqrt(x0) + isqrt(x1) + ... + isqrt(x[N-1]).
- Parametrised successor of the fixed 3-term, 32-bit formula FSMs.
- Sits between a formula distributor (upstream, valid/ready) and one isqrt instance (downstream, valid-only, any fixed or variable latency L ≥ 1).

Parameters:
N_TERMS  3   number of operands x0..x[N-1]; legal range 1..16
W        32  operand and result width; even; isqrt result width is W/2

Ports:
clk          in   1            clock
rst_n        in   1            asynchronous active-low reset
arg_vld      in   1            operand bundle valid
arg_rdy      out  1            block idle and able to accept
mode         in   1            0 = NEST, 1 = SUM; sampled with args
args         in   N_TERMS*W    x_k at args[k*W +: W]; x0 is outermost / first term
res_vld      out  1            one-cycle result pulse
res          out  W            result; 0 when res_vld = 0
isqrt_x_vld  out  1            one-cycle request pulse to isqrt
isqrt_x      out  W            isqrt operand; 0 when isqrt_x_vld = 0
isqrt_y_vld  in   1            isqrt result valid
isqrt_y      in   W/2          isqrt result

Behaviour:
- Reset is asynchronous and active-low; rst_n low clears everything immediately:
  - state = IDLE;
  - idx, acc and all operand registers = 0;
  - every output = 0, except arg_rdy = 1 (IDLE).
- Handshake:
  - A transaction is accepted on the cycle where arg_vld && arg_rdy.
  - arg_rdy = (state == IDLE).
  - On accept: args and mode are latched, idx = N_TERMS-1, acc = 0.
  - arg_vld while busy is ignored. No queueing, and no upstream error signal.
- States:
  - IDLE: on accept go to SEND.
  - SEND: isqrt_x_vld = 1 for exactly one cycle, with isqrt_x = operand(idx). Go to WAIT.
  - WAIT: hold until isqrt_y_vld.
    - On isqrt_y_vld: update acc. If idx == 0 go to DONE; else decrement idx and go to SEND.
  - DONE: res_vld = 1, res = acc for one cycle. Go to IDLE.
- operand(idx):
  - NEST: x[idx] + acc, truncated to W bits (wraps mod 2^W).
  - SUM: x[idx].
- acc update on isqrt_y_vld in WAIT:
  - NEST: acc = zero-extended isqrt_y.
  - SUM: acc = acc + isqrt_y, mod 2^W.
- Terms are processed in the order x[N-1] first down to x0 last, in both modes.
- isqrt_y_vld outside WAIT is ignored: no state change, acc unchanged.
- Latency:
  - Accept at cycle 0; res_vld at cycle N_TERMS*(1+L)+1 for fixed isqrt latency L.
  - Next accept is possible in the cycle after DONE.
- N_TERMS = 1: a single SEND/WAIT pair; NEST and SUM results are identical.
- Reset mid-transaction: aborts the transaction with no res_vld. The isqrt unit shares rst_n, so no stale isqrt_y_vld may be consumed.

Decomposition:
- Package nested_sqrt_pkg holds:
  - state enum (IDLE, SEND, WAIT, DONE), 2 bits;
  - mode enum (MODE_NEST = 0, MODE_SUM = 1);
  - localparam function idx_w(N) = $clog2(N) with a minimum of 1.
- Single module, no sub-module; the isqrt unit is instantiated by the parent.

Test Plan:
- NEST, N=3, W=32, args x0=2, x1=7, x2=4 -> isqrt_x sequence 4, 9, 5 -> res=2, res_vld at cycle 3*(1+L)+1.
- SUM, N=3, x0=16, x1=9, x2=4 -> isqrt_x sequence 4, 9, 16 -> res=9.
- NEST wrap, x0=0xFFFF0001, x1=0xFFFFFFFF, x2=0 -> isqrt_x sequence 0, 0xFFFFFFFF, 0x00000000 (wrapped) -> res=0.
- arg_vld held high throughout two back-to-back bundles -> arg_rdy low while busy; the second bundle is accepted the cycle after res_vld; both results are correct.
- Spurious isqrt_y_vld=1 (y=123) while in SEND or IDLE -> ignored; final result unchanged.
- rst_n asserted during the second WAIT -> all outputs 0 immediately and arg_rdy=1; the next bundle (NEST 2,7,4) still gives res=2.
